// File: rtl/seq_alu.sv
// Handshaked ALU responder: single-cycle logic/arithmetic ops, and shifts
// executed iteratively one bit position per clock.
module seq_alu #(
    parameter int n = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic [2:0]   alu_control,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [n-1:0] result,
    output logic         zero
);
    localparam int lw = $clog2(n);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t         state_reg, state_next;
    logic [n-1:0]   acc_reg, acc_next;
    logic [n-1:0]   result_reg, result_next;
    logic [lw-1:0]  cnt_reg, cnt_next;
    logic           sra_reg, sra_next;
    logic [n-1:0]   sll_step, sra_step, shift_step;

    // One-position shift of the accumulator in both directions.
    genvar gi;
    generate
        for (gi = 0; gi < n; gi++) begin : g_step
            if (gi == 0) begin : g_lsb
                assign sll_step[gi] = 1'b0;
            end else begin : g_sll
                assign sll_step[gi] = acc_reg[gi-1];
            end
            if (gi == n - 1) begin : g_msb
                assign sra_step[gi] = acc_reg[n-1];
            end else begin : g_sra
                assign sra_step[gi] = acc_reg[gi+1];
            end
        end
    endgenerate

    assign shift_step = sra_reg ? sra_step : sll_step;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            acc_reg    <= '0;
            result_reg <= '0;
            cnt_reg    <= '0;
            sra_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            acc_reg    <= acc_next;
            result_reg <= result_next;
            cnt_reg    <= cnt_next;
            sra_reg    <= sra_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        acc_next    = acc_reg;
        result_next = result_reg;
        cnt_next    = cnt_reg;
        sra_next    = sra_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    state_next = DONE;
                    case (alu_control)
                        3'b000: result_next = a + b;
                        3'b001: result_next = a - b;
                        3'b010: result_next = a & b;
                        3'b011: result_next = a | b;
                        3'b100: result_next = a ^ b;
                        3'b101: result_next = ~(a | b);
                        default: begin
                            acc_next = b;
                            cnt_next = a[lw-1:0];
                            sra_next = alu_control[0];
                            // A zero-length shift completes like a logic op.
                            if (a[lw-1:0] == '0) begin
                                result_next = b;
                            end else begin
                                state_next = SHIFT;
                            end
                        end
                    endcase
                end
            end
            SHIFT: begin
                acc_next = shift_step;
                cnt_next = cnt_reg - lw'(1);
                if (cnt_reg == lw'(1)) begin
                    result_next = shift_step;
                    state_next  = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign result    = result_reg;
    assign zero      = (result_reg == '0);
endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed cases plus randomized ops against
// an arithmetic reference model.
module tb_seq_alu;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  alu_control;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;

    int checks = 0;
    int errors = 0;

    seq_alu #(.n(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .alu_control(alu_control), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .zero(zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model_result(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        logic signed [31:0] sy;
        int sh;
        sy = y;
        sh = int'(x % 32);
        case (op)
            3'd0: return x + y;
            3'd1: return x - y;
            3'd2: return x & y;
            3'd3: return x | y;
            3'd4: return x ^ y;
            3'd5: return ~(x | y);
            3'd6: return y << sh;
            default: return sy >>> sh;
        endcase
    endfunction

    function automatic int model_latency(input logic [2:0] op, input logic [31:0] x);
        return (op >= 3'd6) ? 1 + int'(x % 32) : 1;
    endfunction

    // Issues one request with out_ready high; returns the result and the
    // edge count (accept edge = 1) at which out_valid was first seen.
    task automatic do_op(input logic [2:0] op, input logic [31:0] xa, input logic [31:0] xb,
                         output logic [31:0] res, output logic z, output int lat);
        alu_control = op; a = xa; b = xb; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom; alu_control = 3'($urandom);
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        res = result; z = zero;
        $display("op=%0d a=%h b=%h -> result=%h zero=%0d latency=%0d", op, xa, xb, res, z, lat);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; alu_control = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'h0 || zero !== 1'b1) begin
            errors++;
            $display("FAIL reset got in_ready=%b out_valid=%b result=%h zero=%b want 1 0 00000000 1",
                     in_ready, out_valid, result, zero);
        end
    endtask

    task automatic test_alu_ops();
        logic [2:0]  to[6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
        logic [31:0] ta[6] = '{32'h00010001, 32'h00020003, 32'hFF00FF00, 32'hFF00FF00, 32'hFF00FF00, 32'h0F0F0F0F};
        logic [31:0] tb[6] = '{32'h00010002, 32'h00010001, 32'h00FF00FF, 32'h00FF00FF, 32'h00FF00FF, 32'hF0F0F0F0};
        logic [31:0] te[6] = '{32'h00020003, 32'h00010002, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
        logic [31:0] res;
        logic z;
        int lat;
        for (int i = 0; i < 6; i++) begin
            do_op(to[i], ta[i], tb[i], res, z, lat);
            checks++;
            if (res !== te[i] || z !== (te[i] == 32'h0) || lat != 1) begin
                errors++;
                $display("FAIL alu_op%0d got result=%h zero=%b lat=%0d want %h %b 1",
                         i, res, z, lat, te[i], (te[i] == 32'h0));
            end
        end
    endtask

    task automatic test_shifts();
        logic [2:0]  to[5] = '{3'd6, 3'd7, 3'd7, 3'd6, 3'd6};
        logic [31:0] ta[5] = '{32'd5, 32'd5, 32'd0, 32'd31, 32'h25};
        logic [31:0] tb[5] = '{32'h1, 32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'h1};
        logic [31:0] te[5] = '{32'h20, 32'hFC000000, 32'h80000000, 32'h80000000, 32'h20};
        int          tl[5] = '{6, 6, 1, 32, 6};
        logic [31:0] res;
        logic z;
        int lat;
        for (int i = 0; i < 5; i++) begin
            do_op(to[i], ta[i], tb[i], res, z, lat);
            checks++;
            if (res !== te[i] || z !== 1'b0 || lat != tl[i]) begin
                errors++;
                $display("FAIL shift%0d got result=%h zero=%b lat=%0d want %h 0 %0d",
                         i, res, z, lat, te[i], tl[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] res;
        logic z;
        int lat;
        alu_control = 3'd0; a = 32'd3; b = 32'd4; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (out_valid !== 1'b1 || result !== 32'd7 || in_ready !== 1'b0 || zero !== 1'b0) begin
                errors++;
                $display("FAIL hold%0d got out_valid=%b result=%h in_ready=%b zero=%b want 1 00000007 0 0",
                         i, out_valid, result, in_ready, zero);
            end
            in_valid = (i == 3 || i == 4);
            alu_control = 3'd1; a = 32'd100; b = 32'd1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL release got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || result !== 32'd7) begin
            errors++;
            $display("FAIL no_queue got out_valid=%b result=%h want 0 00000007", out_valid, result);
        end
        do_op(3'd0, 32'd10, 32'd20, res, z, lat);
        checks++;
        if (res !== 32'd30 || lat != 1) begin
            errors++;
            $display("FAIL after_bp got result=%h lat=%0d want 0000001e 1", res, lat);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] res;
        logic z;
        int lat;
        do_op(3'd0, 32'hFFFFFFFF, 32'd1, res, z, lat);
        checks++;
        if (res !== 32'h0 || z !== 1'b1) begin
            errors++;
            $display("FAIL add_wrap got result=%h zero=%b want 00000000 1", res, z);
        end
        do_op(3'd1, 32'd0, 32'd1, res, z, lat);
        checks++;
        if (res !== 32'hFFFFFFFF || z !== 1'b0) begin
            errors++;
            $display("FAIL sub_wrap got result=%h zero=%b want ffffffff 0", res, z);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] res;
        logic z;
        int lat;
        int seen;
        seen = 0;
        alu_control = 3'd6; a = 32'd20; b = 32'd1; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int e = 2; e <= 4; e++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        if (out_valid) seen++;
        rst_n = 1'b1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'h0 || zero !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset got in_ready=%b out_valid=%b result=%h zero=%b want 1 0 00000000 1",
                     in_ready, out_valid, result, zero);
        end
        for (int e = 0; e < 20; e++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL mid_reset_valid got %0d out_valid cycles want 0", seen);
        end
        do_op(3'd0, 32'd1, 32'd1, res, z, lat);
        checks++;
        if (res !== 32'd2 || lat != 1) begin
            errors++;
            $display("FAIL post_reset_add got result=%h lat=%0d want 00000002 1", res, lat);
        end
    endtask

    task automatic test_back_to_back();
        int pulses;
        int accepts;
        pulses = 0; accepts = 0;
        alu_control = 3'd0; a = 32'd5; b = 32'd6; in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (in_ready) accepts++;
            @(posedge clk); #1;
            if (out_valid) begin
                pulses++;
                checks++;
                if (result !== 32'd11) begin
                    errors++;
                    $display("FAIL b2b_result got %h want 0000000b", result);
                end
            end
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (pulses != 6 || accepts != 6) begin
            errors++;
            $display("FAIL b2b_rate got pulses=%0d accepts=%0d want 6 6", pulses, accepts);
        end
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] xa, xb, exp, res;
        logic z;
        int lat;
        for (int i = 0; i < 30; i++) begin
            op = 3'($urandom_range(0, 7));
            xa = $urandom;
            xb = $urandom;
            if (i % 5 == 0) xb = xa;
            exp = model_result(op, xa, xb);
            do_op(op, xa, xb, res, z, lat);
            checks++;
            if (res !== exp || z !== (exp == 32'h0) || lat != model_latency(op, xa)) begin
                errors++;
                $display("FAIL random%0d op=%0d got result=%h zero=%b lat=%0d want %h %b %0d",
                         i, op, res, z, lat, exp, (exp == 32'h0), model_latency(op, xa));
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu_ops();
        test_shifts();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
